// File: rtl/flappy_pkg.sv
// Shared types and frame timing for the flappy input path.
// Also sizes the bird_physics tick counter.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_t;

  localparam int FRAME_TICK_BITS = 20;
  localparam int CLK_HZ          = 50_000_000;
  localparam int DEBOUNCE_MS     = 10;
  localparam int DEBOUNCE_DEF    = (CLK_HZ / 1000) * DEBOUNCE_MS;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flap_input_ctrl_debounce.sv
// Button synchroniser plus debounce FSM.
// Emits one press_pulse per accepted press.
module btn_debounce
  import flappy_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  deb_state_t             state_q;
  logic [CW-1:0]          cnt_q;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= PRESSED;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state_q <= PRESSED;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Decoded from registered state so the hold starts on the accepting edge
  assign press_pulse = (state_q == PRESS_WAIT) && btn_s &&
                       (cnt_q == CNT_MAX);

endmodule

// File: rtl/flap_input_ctrl.sv
// Turns debounced presses into frame-length flap_btn holds.
// One press may queue behind a running hold.
module flap_input_ctrl
  import flappy_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int TICK_BITS       = FRAME_TICK_BITS,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_raw,
  output logic               flap_btn,
  output logic               flap_queued,
  output logic [COUNT_W-1:0] press_count
);

  logic                 press_pulse;
  logic                 flap_q, flap_d;
  logic                 queued_q, queued_d;
  logic [TICK_BITS-1:0] hold_q, hold_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 hold_end;

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .press_pulse (press_pulse)
  );

  assign hold_end = (hold_q == '1);

  always_comb begin
    flap_d   = flap_q;
    queued_d = queued_q;
    hold_d   = hold_q;
    count_d  = count_q;
    if (!flap_q) begin
      if (press_pulse) begin
        flap_d  = 1'b1;
        hold_d  = '0;
        count_d = count_q + COUNT_W'(1);
      end
    end else begin
      // Wraps to 0 on the end cycle, seamlessly starting any follow-on hold
      hold_d = hold_q + TICK_BITS'(1);
      if (hold_end) begin
        if (queued_q) begin
          queued_d = 1'b0;
        end else if (press_pulse) begin
          count_d = count_q + COUNT_W'(1);
        end else begin
          flap_d = 1'b0;
        end
      end else if (press_pulse && !queued_q) begin
        queued_d = 1'b1;
        count_d  = count_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flap_q   <= 1'b0;
      queued_q <= 1'b0;
      hold_q   <= '0;
      count_q  <= '0;
    end else begin
      flap_q   <= flap_d;
      queued_q <= queued_d;
      hold_q   <= hold_d;
      count_q  <= count_d;
    end
  end

  assign flap_btn    = flap_q;
  assign flap_queued = queued_q;
  assign press_count = count_q;

endmodule
